// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
// Imported by rr_pick and reg_write_arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Edges from request sample to the next possible grant when req is held.
    localparam int ARB_CYCLES = 3;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: first set req bit scanning from ptr upward (mod N_REQ).
// With REG_ARB_FIXED_PRIO_EN defined the scan always starts at index 0 and ptr is ignored.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   winner,
    output logic             found
);

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IDW'(i);
                found  = 1'b1;
            end
        end
    end
`else
    // Scan from the far end back towards ptr so the closest candidate is written last.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        found  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                winner = IDW'((int'(ptr) + k) % N_REQ);
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/reg_write_arbiter.sv
// One shared WIDTH-bit register written by N_REQ requesters through a req/gnt/ack handshake.
// Round-robin by default; REG_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [IDW-1:0]         gnt_id,
    output logic                   ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid
);

    state_e             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [IDW-1:0]     gnt_id_q;
    logic [IDW-1:0]     ptr_q;
    logic               ack_q;
    logic [WIDTH-1:0]   q_q;
    logic               q_valid_q;

    logic [IDW-1:0]     pick_id;
    logic               pick_found;
    logic [WIDTH-1:0]   lane_d;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_id),
        .found  (pick_found)
    );

    assign lane_d = wdata[int'(gnt_id_q) * WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q    <= N_REQ'(1) << pick_id;
                        gnt_id_q <= pick_id;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    // A grantee that lets go of req before commit forfeits the slot.
                    if (req[gnt_id_q]) begin
                        q_q       <= lane_d;
                        q_valid_q <= 1'b1;
                        ack_q     <= 1'b1;
`ifndef REG_ARB_FIXED_PRIO_EN
                        ptr_q     <= IDW'(wrap_inc(int'(gnt_id_q), N_REQ));
`endif
                        state_q   <= DONE;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign ack     = ack_q;
    assign busy    = (state_q != IDLE);
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed plus randomized bench for reg_write_arbiter against a transaction-level model.
// Honours REG_ARB_FIXED_PRIO_EN in the model when the design is built with it.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N*W-1:0] wdata;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         ack;
    logic         busy;
    logic [W-1:0] q;
    logic         q_valid;

    int checks = 0;
    int passed = 0;
    int edge_cnt = 0;
    int last_ack_edge = 0;

    // Reference state: arbitration pointer plus the last committed value.
    int           m_ptr = 0;
    logic [W-1:0] m_q   = '0;
    logic         m_qv  = 1'b0;

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .ack     (ack),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef REG_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [W-1:0] lane(input int w);
        logic [N*W-1:0] v;
        v = wdata;
        return v[w*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"},  32'(gnt),     32'(0));
        check({tag, ".busy"}, 32'(busy),    32'(0));
        check({tag, ".ack"},  32'(ack),     32'(0));
        check({tag, ".q"},    32'(q),       32'(m_q));
        check({tag, ".qv"},   32'(q_valid), 32'(m_qv));
    endtask

    // One handshake starting from IDLE at posedge+1; returns in IDLE at posedge+1.
    task automatic do_write(input string tag, input logic [N-1:0] r,
                            input bit abort, input bit hold, input bit rnd);
        int w;
        req = r;
        w = pick(r);
        tick();
        check({tag, ".gnt"},    32'(gnt),    32'(1 << w));
        check({tag, ".gnt_id"}, 32'(gnt_id), 32'(w));
        check({tag, ".busy1"},  32'(busy),   32'(1));
        check({tag, ".ack1"},   32'(ack),    32'(0));
        check({tag, ".q1"},     32'(q),      32'(m_q));
        if (abort) begin
            req = rnd ? (N'($urandom) & ~N'(1 << w)) : '0;
        end else if (rnd) begin
            req   = N'($urandom) | N'(1 << w);
            wdata = $urandom;
        end
        tick();
        if (abort) begin
            check_idle({tag, ".abort"});
            return;
        end
        m_q  = lane(w);
        m_qv = 1'b1;
`ifndef REG_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % N;
`endif
        check({tag, ".ack"},   32'(ack),     32'(1));
        check({tag, ".gnt2"},  32'(gnt),     32'(1 << w));
        check({tag, ".q"},     32'(q),       32'(m_q));
        check({tag, ".qv"},    32'(q_valid), 32'(1));
        check({tag, ".busy2"}, 32'(busy),    32'(1));
        last_ack_edge = edge_cnt;
        if (!hold) req = '0;
        tick();
        check_idle({tag, ".done"});
    endtask

    initial begin
        int prev_ack;
        int rr_id [5];
        logic [W-1:0] rr_q [5];

        rst_n = 1'b0;
        req   = '0;
        wdata = '0;

        // Reset asserted and released away from a clock edge.
        #10;
        check_idle("rst_hold");
        check("rst_hold.gnt_id", 32'(gnt_id), 32'(0));
        #17;
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check_idle("rst_quiet");
        end

        // Continuous all-request stream: fairness order and one ack per ARB_CYCLES edges.
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef REG_ARB_FIXED_PRIO_EN
        rr_id = '{0, 0, 0, 0, 0};
        rr_q  = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
        rr_id = '{0, 1, 2, 3, 0};
        rr_q  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`endif
        for (int i = 0; i < 5; i++) begin
            do_write("rr", 4'b1111, 1'b0, 1'b1, 1'b0);
            check("rr.order", 32'(dut.gnt_id), 32'(rr_id[i]));
            check("rr.qseq",  32'(q),          32'(rr_q[i]));
            if (i > 0) check("rr.spacing", 32'(last_ack_edge - prev_ack), 32'(ARB_CYCLES));
            prev_ack = last_ack_edge;
        end
        req = '0;
        tick();
        check_idle("rr_end");

        // Single write from requester 1.
        wdata = {8'h00, 8'h00, 8'hA5, 8'h00};
        do_write("single", 4'b0010, 1'b0, 1'b0, 1'b0);
        check("single.val", 32'(q), 32'(8'hA5));

        // Abort: requester 2 withdraws during GRANT; pointer must not move.
        wdata = {8'h00, 8'h5C, 8'h00, 8'h00};
        do_write("abort", 4'b0100, 1'b1, 1'b0, 1'b0);
        wdata = {8'h43, 8'h42, 8'h41, 8'h40};
        do_write("post_abort", 4'b1111, 1'b0, 1'b0, 1'b0);

        // Wrap: with ptr at 3 requester 3 goes first, then 0, leaving ptr at 1.
        wdata = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        do_write("wrap_a", 4'b1001, 1'b0, 1'b1, 1'b0);
        do_write("wrap_b", 4'b1001, 1'b0, 1'b0, 1'b0);
        do_write("wrap_c", 4'b0011, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with noise on non-granted requesters and late wdata changes.
        for (int i = 0; i < 150; i++) begin
            wdata = $urandom;
            do_write("rand", N'($urandom_range(1, (1 << N) - 1)),
                     ($urandom_range(0, 4) == 0), 1'b0, 1'b1);
        end
        req = '0;
        tick();
        check_idle("rand_end");

        // Asynchronous reset in DONE, between clock edges.
        wdata = {8'h77, 8'h66, 8'h55, 8'h44};
        req   = 4'b0100;
        tick();
        tick();
        check("arst.pre_ack", 32'(ack), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        m_ptr = 0;
        m_q   = '0;
        m_qv  = 1'b0;
        check_idle("arst");
        check("arst.gnt_id", 32'(gnt_id), 32'(0));
        req = '0;
        #3;
        rst_n = 1'b1;
        tick();
        check_idle("arst_after");

        // Pointer back at 0 after reset.
        wdata = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        do_write("arst_rr", 4'b1110, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop register (async active-low reset) among N_REQ requesters.
- Round-robin arbitration with a req/gnt/ack handshake.
- One write completes every 3 cycles; the output register holds the last committed value.
- Sits between requester blocks and the downstream logic that consumes the shared register value.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of the shared register and of each write-data lane.
- IDW, $clog2(N_REQ), width of the grant index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester write request, level-held until ack.
- wdata  in  N_REQ*WIDTH  write data; lane i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, registered.
- gnt_id  out  IDW  index of current/last grantee.
- ack  out  1  one-cycle pulse: write committed.
- busy  out  1  high whenever state is not IDLE.
- q  out  WIDTH  shared register contents.
- q_valid  out  1  set by first committed write, sticky until reset.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=IDLE; gnt=0, gnt_id=0, ack=0, busy=0, q=0, q_valid=0; rr pointer ptr=0.
- States: IDLE, GRANT, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise winner w = first set bit of req scanning ptr, ptr+1, ... mod N_REQ.
  - Next edge: gnt=onehot(w), gnt_id=w, state=GRANT.
- GRANT (1 cycle):
  - If req[w] is still 1 at the edge: q<=wdata lane w, q_valid<=1, ack<=1, ptr<=(w+1) mod N_REQ, state=DONE.
  - If req[w] dropped: abort. No q update, no ack, ptr unchanged, gnt<=0, state=IDLE.
- DONE (1 cycle):
  - ack=1, gnt held.
  - Next edge: ack<=0, gnt<=0, state=IDLE.
  - The requester must drop req in the cycle after seeing ack. If req[w] is still high in IDLE it is re-arbitrated normally; w now has lowest priority.
- Latency: req sampled at edge k gives gnt at k, q/ack at k+1, idle at k+2. Back-to-back writes every 3 edges.
- req changes of non-granted requesters during GRANT/DONE are ignored; they are evaluated only in IDLE.
- wdata is sampled only at the GRANT→DONE edge.
- Pointer wrap: w=N_REQ-1 gives ptr=0.
- Reset asserted mid-GRANT/DONE: the write is lost if it has not yet committed, and all outputs clear asynchronously.
- Invariants:
  - gnt is one-hot or zero.
  - ack implies state==DONE.
  - busy == (state!=IDLE).

Optional Feature:
- Macro REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index always wins; ptr is held at 0 and never updated.
- Undefined: round-robin as above.
- The handshake and timing are identical in both modes.

Decomposition:
- Package reg_arb_pkg holds:
  - State encoding enum: IDLE=2'd0, GRANT=2'd1, DONE=2'd2.
  - Constant ARB_CYCLES=3.
- Sub-module rr_pick: combinational. Inputs req and ptr; outputs winner index and a found flag. Instantiated once in reg_write_arbiter. The fixed-priority variant is inside rr_pick under the macro.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 27 ns, then release; drive req=4'b0000.
  - Required: q=0, gnt=0, busy=0, q_valid=0 throughout; nothing changes until a req arrives.
- Single write:
  - Stimulus: req=4'b0010, lane1=8'hA5.
  - Required: gnt=0010 and gnt_id=1 one edge later; next edge q=8'hA5, ack=1, q_valid=1; next edge ack=0, busy=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously, lanes=8'h10/8'h11/8'h12/8'h13.
  - Required: grant order 0,1,2,3,0; q sequence 10,11,12,13,10; ack every 3 edges.
  - With REG_ARB_FIXED_PRIO_EN: always 0, q always 8'h10.
- Abort:
  - Stimulus: req=4'b0100, then drop req[2] during GRANT.
  - Required: no ack, q unchanged, ptr unchanged; return to IDLE the next edge.
- Async reset mid-write:
  - Stimulus: assert rst_n low during DONE, between clock edges.
  - Required: ack, gnt, q and q_valid go to 0 immediately, without waiting for a clock edge.
- Wrap:
  - Stimulus: req=4'b1001 with ptr=3.
  - Required: requester 3 granted first, then 0; ptr ends at 1.
